ldpc_wb_channel_hub: RTL and testbench

//  Wishbone slave hub between the management SoC Wishbone port and NUM_CH LDPC encoder/decoder channels.
//  - Decodes each access to one channel window, forwards it, and returns ack and read data.
//  - Bounds every forwarded access with a timeout.
//  - Aggregates per-channel interrupts into sticky, maskable status driving user_irq.
//  - Sits in the user project wrapper, replacing direct single-core wiring so several cores share one bus.

---
 rtl/ldpc_wb_channel_hub.sv | 167 ++++++++++++++++
 tb/tb_ldpc_wb_channel_hub.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldpc_wb_channel_hub.sv
// Wishbone hub that fans the management bus out to NUM_CH LDPC channel windows,
// bounds each forwarded access with a timeout and gathers channel interrupts.
module ldpc_wb_channel_hub #(
  parameter int          NUM_CH    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          WIN_BITS  = 8,
  parameter int          TIMEOUT   = 15
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 wbs_cyc_i,
  input  logic                 wbs_stb_i,
  input  logic                 wbs_we_i,
  input  logic [3:0]           wbs_sel_i,
  input  logic [31:0]          wbs_adr_i,
  input  logic [31:0]          wbs_dat_i,
  output logic                 wbs_ack_o,
  output logic [31:0]          wbs_dat_o,
  output logic [NUM_CH-1:0]    ch_stb_o,
  output logic                 ch_we_o,
  output logic [3:0]           ch_sel_o,
  output logic [WIN_BITS-1:0]  ch_adr_o,
  output logic [31:0]          ch_dat_o,
  input  logic [NUM_CH-1:0]    ch_ack_i,
  input  logic [32*NUM_CH-1:0] ch_dat_i,
  input  logic [NUM_CH-1:0]    ch_irq_i,
  output logic [2:0]           user_irq
);

  localparam int CHW = $clog2(NUM_CH + 1);
  localparam int HI  = WIN_BITS + CHW;

  typedef enum logic [1:0] {IDLE, FWD, RESP, LRESP} state_t;

  state_t              state, state_next;
  logic                hit, is_local, is_ch, req_go;
  logic [CHW-1:0]      bus_idx, idx_q;
  logic [NUM_CH-1:0]   onehot;
  logic                ack_sel, timeout_hit, fwd_to;
  logic [31:0]         dat_sel, resp_dat;
  logic [7:0]          timer;
  logic [NUM_CH-1:0]   irq_d, irq_status, irq_mask, clr_status;
  logic                to_flag, to_clr, lwrite;
  logic [3:0]          to_ch;
  logic [1:0]          off;
  logic [31:0]         wmask, wdata_m, local_rd;

  assign hit      = (wbs_adr_i[31:HI] == BASE_ADDR[31:HI]);
  assign bus_idx  = wbs_adr_i[WIN_BITS +: CHW];
  assign is_local = (bus_idx == {CHW{1'b1}});
  assign is_ch    = (int'(bus_idx) < NUM_CH);
  // A new request is refused during the ack cycle so a master that still holds
  // stb on the ack edge does not launch a second access.
  assign req_go   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & hit;
  assign timeout_hit = (timer == 8'(TIMEOUT));

  always_comb begin
    ack_sel = 1'b0;
    dat_sel = '0;
    onehot  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (idx_q == CHW'(i)) begin
        ack_sel = ch_ack_i[i];
        dat_sel = ch_dat_i[32*i +: 32];
      end
      onehot[i] = (bus_idx == CHW'(i));
    end
  end

  always_comb begin
    state_next = state;
    fwd_to     = 1'b0;
    case (state)
      IDLE: begin
        if (req_go && is_local)   state_next = LRESP;
        else if (req_go && is_ch) state_next = FWD;
      end
      FWD: begin
        if (!wbs_cyc_i)   state_next = IDLE;
        else if (ack_sel) state_next = RESP;
        else if (timeout_hit) begin
          state_next = RESP;
          fwd_to     = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      LRESP:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Local registers act on the request fields captured when the access was accepted.
  always_comb begin
    wmask      = {{8{ch_sel_o[3]}}, {8{ch_sel_o[2]}}, {8{ch_sel_o[1]}}, {8{ch_sel_o[0]}}};
    wdata_m    = ch_dat_o & wmask;
    off        = ch_adr_o[3:2];
    lwrite     = (state == LRESP) && ch_we_o;
    clr_status = (lwrite && off == 2'd0) ? wdata_m[NUM_CH-1:0] : '0;
    to_clr     = lwrite && (off == 2'd2) && wdata_m[0];
    case (off)
      2'd0:    local_rd = 32'(irq_status);
      2'd1:    local_rd = 32'(irq_mask);
      2'd2:    local_rd = {20'd0, to_ch, 7'd0, to_flag};
      default: local_rd = {8'h1D, 8'h01, 8'h00, 8'(NUM_CH)};
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      wbs_ack_o  <= 1'b0;
      wbs_dat_o  <= '0;
      ch_stb_o   <= '0;
      ch_we_o    <= 1'b0;
      ch_sel_o   <= '0;
      ch_adr_o   <= '0;
      ch_dat_o   <= '0;
      idx_q      <= '0;
      timer      <= '0;
      resp_dat   <= '0;
      irq_d      <= '0;
      irq_status <= '0;
      irq_mask   <= '0;
      to_flag    <= 1'b0;
      to_ch      <= '0;
      user_irq   <= '0;
    end else begin
      state     <= state_next;
      wbs_ack_o <= (state == RESP) || (state == LRESP);
      if (state == RESP)       wbs_dat_o <= resp_dat;
      else if (state == LRESP) wbs_dat_o <= local_rd;

      if (state == IDLE && state_next != IDLE) begin
        ch_we_o  <= wbs_we_i;
        ch_sel_o <= wbs_sel_i;
        ch_adr_o <= wbs_adr_i[WIN_BITS-1:0];
        ch_dat_o <= wbs_dat_i;
        idx_q    <= bus_idx;
        timer    <= 8'd1;
      end else if (state == FWD) begin
        timer <= timer + 8'd1;
      end

      if (state == IDLE && state_next == FWD) ch_stb_o <= onehot;
      else if (state_next != FWD)             ch_stb_o <= '0;

      if (state == FWD && state_next == RESP)
        resp_dat <= fwd_to ? 32'hDEAD_BEEF : dat_sel;

      // New interrupt edges take priority over a simultaneous W1C.
      irq_d      <= ch_irq_i;
      irq_status <= (irq_status & ~clr_status) | (ch_irq_i & ~irq_d);
      if (lwrite && off == 2'd1)
        irq_mask <= (irq_mask & ~wmask[NUM_CH-1:0]) | wdata_m[NUM_CH-1:0];

      if (fwd_to) begin
        to_flag <= 1'b1;
        to_ch   <= 4'(idx_q);
      end else if (to_clr) begin
        to_flag <= 1'b0;
      end

      user_irq <= {1'b0, to_flag, |(irq_status & irq_mask)};
    end
  end

endmodule

// File: tb/tb_ldpc_wb_channel_hub.sv
// Self-checking bench for ldpc_wb_channel_hub: vector table, hand-built corner
// sequences and randomized channel traffic against a latency/data model.
module tb_ldpc_wb_channel_hub;

  localparam int          NUM_CH   = 4;
  localparam int          WIN_BITS = 8;
  localparam int          TIMEOUT  = 15;
  localparam logic [31:0] BASE     = 32'h3000_0000;
  localparam logic [31:0] LOC      = 32'h3000_0700;

  logic                 wb_clk_i, wb_rst_i;
  logic                 wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]           wbs_sel_i;
  logic [31:0]          wbs_adr_i, wbs_dat_i;
  logic                 wbs_ack_o;
  logic [31:0]          wbs_dat_o;
  logic [NUM_CH-1:0]    ch_stb_o;
  logic                 ch_we_o;
  logic [3:0]           ch_sel_o;
  logic [WIN_BITS-1:0]  ch_adr_o;
  logic [31:0]          ch_dat_o;
  logic [NUM_CH-1:0]    ch_ack_i;
  logic [32*NUM_CH-1:0] ch_dat_i;
  logic [NUM_CH-1:0]    ch_irq_i;
  logic [2:0]           user_irq;

  ldpc_wb_channel_hub #(
    .NUM_CH(NUM_CH), .BASE_ADDR(BASE), .WIN_BITS(WIN_BITS), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .ch_stb_o(ch_stb_o), .ch_we_o(ch_we_o), .ch_sel_o(ch_sel_o),
    .ch_adr_o(ch_adr_o), .ch_dat_o(ch_dat_o), .ch_ack_i(ch_ack_i),
    .ch_dat_i(ch_dat_i), .ch_irq_i(ch_irq_i), .user_irq(user_irq)
  );

  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  // Channel slaves: ack once their strobe has been seen for ch_delay[i] edges.
  int          ch_delay [NUM_CH];
  logic [31:0] ch_rdata [NUM_CH];
  int          ch_cnt   [NUM_CH];

  always @(posedge wb_clk_i)
    for (int i = 0; i < NUM_CH; i++) ch_cnt[i] <= ch_stb_o[i] ? ch_cnt[i] + 1 : 0;

  always_comb begin
    ch_ack_i = '0;
    ch_dat_i = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_ack_i[i]         = ch_stb_o[i] && (ch_cnt[i] >= ch_delay[i]);
      ch_dat_i[32*i +: 32] = ch_rdata[i];
    end
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Edges from the accepting edge until ack is visible; timeouts end at TIMEOUT+1.
  function automatic int model_lat(input int d);
    return (d < TIMEOUT) ? d + 2 : TIMEOUT + 1;
  endfunction

  function automatic logic [31:0] model_dat(input int d, input logic [31:0] v);
    return (d < TIMEOUT) ? v : 32'hDEAD_BEEF;
  endfunction

  task automatic apply_stimulus(input bit we, input logic [31:0] adr, input logic [31:0] wdat,
                                input logic [3:0] sel, input int exp_idx,
                                output bit got_ack, output int lat, output logic [31:0] rdat,
                                output bit stb_bad, output bit field_bad, output bit saw_stb,
                                output bit pulse_bad);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = wdat; wbs_sel_i = sel;
    got_ack = 0; lat = -1; rdat = '0; stb_bad = 0; field_bad = 0; saw_stb = 0; pulse_bad = 0;
    for (int k = 0; k < TIMEOUT + 8 && !got_ack; k++) begin
      @(posedge wb_clk_i); #1;
      if ($countones(ch_stb_o) > 1) stb_bad = 1;
      if (ch_stb_o != '0) begin
        saw_stb = 1;
        if (exp_idx < 0 || ch_stb_o != (NUM_CH'(1) << exp_idx)) stb_bad = 1;
        if (ch_adr_o != adr[WIN_BITS-1:0] || ch_we_o != we || ch_sel_o != sel || ch_dat_o != wdat)
          field_bad = 1;
      end
      if (wbs_ack_o) begin
        got_ack = 1; lat = k; rdat = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(posedge wb_clk_i); #1;
    if (wbs_ack_o) pulse_bad = 1;
    if (ch_stb_o != '0) stb_bad = 1;
  endtask

  task automatic run_access(input string name, input bit we, input logic [31:0] adr,
                            input logic [31:0] wdat, input logic [3:0] sel, input int exp_idx,
                            input bit exp_ack, input int exp_lat, input logic [31:0] exp_dat,
                            input logic [31:0] exp_mask);
    bit got, sb, fb, ss, pb;
    int lat;
    logic [31:0] rd;
    apply_stimulus(we, adr, wdat, sel, exp_idx, got, lat, rd, sb, fb, ss, pb);
    check_output({name, " ack"}, 32'(got), 32'(exp_ack));
    if (exp_ack) begin
      check_output({name, " latency"}, 32'(lat), 32'(exp_lat));
      if (exp_mask != '0) check_output({name, " data"}, rd & exp_mask, exp_dat & exp_mask);
      check_output({name, " ack pulse"}, 32'(pb), 32'd0);
    end
    check_output({name, " stb seen"}, 32'(ss), 32'(exp_idx >= 0));
    check_output({name, " stb onehot"}, 32'(sb), 32'd0);
    if (ss) check_output({name, " fwd fields"}, 32'(fb), 32'd0);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdat;
    int          ch;
    int          delay;
    logic [31:0] ch_data;
    bit          exp_ack;
    int          exp_lat;
    logic [31:0] exp_dat;
    logic [31:0] exp_mask;
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    bit flag, m_to_flag;
    int m_to_ch;
    wb_rst_i = 1'b1; wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_sel_i = '0; wbs_adr_i = '0; wbs_dat_i = '0; ch_irq_i = '0;
    for (int i = 0; i < NUM_CH; i++) begin ch_delay[i] = 0; ch_rdata[i] = '0; end

    vecs[0] = '{1'b0, 32'h3000_0210, 32'h0,         2, 2,    32'h1234_5678, 1'b1, 4,  32'h1234_5678, 32'hFFFF_FFFF};
    vecs[1] = '{1'b0, 32'h3000_03FC, 32'h1111_2222, 3, 0,    32'hA5A5_5A5A, 1'b1, 2,  32'hA5A5_5A5A, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 32'h3000_0144, 32'h0,         1, 14,   32'h0BAD_F00D, 1'b1, 16, 32'h0BAD_F00D, 32'hFFFF_FFFF};
    vecs[3] = '{1'b0, 32'h3000_0144, 32'h0,         1, 15,   32'h0BAD_F00D, 1'b1, 16, 32'hDEAD_BEEF, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'h3000_070C, 32'h0,        -1, 0,    32'h0,         1'b1, 1,  32'h0001_0004, 32'h00FF_FFFF};
    vecs[5] = '{1'b0, 32'h3000_0500, 32'h0,        -1, 0,    32'h0,         1'b0, 0,  32'h0,         32'h0};
    vecs[6] = '{1'b1, 32'h2000_0100, 32'h5,        -1, 0,    32'h0,         1'b0, 0,  32'h0,         32'h0};
    vecs[7] = '{1'b1, 32'h3000_0000, 32'hCAFE_0001, 0, 1000, 32'h7777_7777, 1'b1, 16, 32'hDEAD_BEEF, 32'hFFFF_FFFF};

    repeat (3) @(posedge wb_clk_i);
    #1;
    check_output("reset ch_stb", 32'(ch_stb_o), 32'd0);
    check_output("reset ack", 32'(wbs_ack_o), 32'd0);
    check_output("reset dat", wbs_dat_o, 32'd0);
    check_output("reset user_irq", 32'(user_irq), 32'd0);
    @(negedge wb_clk_i); wb_rst_i = 1'b0;

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].ch >= 0) begin
        ch_delay[vecs[v].ch] = vecs[v].delay;
        ch_rdata[vecs[v].ch] = vecs[v].ch_data;
      end
      run_access($sformatf("vec%0d", v), vecs[v].we, vecs[v].adr, vecs[v].wdat, 4'hF,
                 vecs[v].ch, vecs[v].exp_ack, vecs[v].exp_lat, vecs[v].exp_dat, vecs[v].exp_mask);
    end

    // Timeout status, its interrupt and its W1C clear.
    check_output("timeout user_irq1", 32'(user_irq[1]), 32'd1);
    run_access("to_status rd", 0, LOC | 32'h8, 32'h0, 4'hF, -1, 1, 1, 32'h0000_0001, 32'hFFFF_FFFF);
    run_access("to_status w1c", 1, LOC | 32'h8, 32'h1, 4'hF, -1, 1, 1, 32'h0, 32'h0);
    run_access("to_status rd2", 0, LOC | 32'h8, 32'h0, 4'hF, -1, 1, 1, 32'h0, 32'hFFFF_FFFF);
    repeat (2) @(posedge wb_clk_i);
    #1 check_output("timeout user_irq1 clr", 32'(user_irq), 32'd0);

    // Interrupt edge capture, byte-select on mask writes, and set beating W1C.
    run_access("mask wr", 1, LOC | 32'h4, 32'h2, 4'hF, -1, 1, 1, 32'h0, 32'h0);
    run_access("mask wr sel", 1, LOC | 32'h4, 32'hFFFF_FFFF, 4'b0010, -1, 1, 1, 32'h0, 32'h0);
    run_access("mask rd", 0, LOC | 32'h4, 32'h0, 4'hF, -1, 1, 1, 32'h2, 32'hFFFF_FFFF);
    @(negedge wb_clk_i); ch_irq_i[1] = 1'b1;
    @(negedge wb_clk_i); ch_irq_i[1] = 1'b0;
    run_access("status rd", 0, LOC, 32'h0, 4'hF, -1, 1, 1, 32'h2, 32'hFFFF_FFFF);
    check_output("irq user_irq0", 32'(user_irq), 32'd1);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = LOC; wbs_dat_i = 32'h2; wbs_sel_i = 4'hF;
    @(posedge wb_clk_i); #1 ch_irq_i[1] = 1'b1;
    @(posedge wb_clk_i); #1;
    check_output("w1c race ack", 32'(wbs_ack_o), 32'd1);
    wbs_cyc_i = 0; wbs_stb_i = 0;
    @(negedge wb_clk_i); ch_irq_i[1] = 1'b0;
    run_access("status set wins", 0, LOC, 32'h0, 4'hF, -1, 1, 1, 32'h2, 32'hFFFF_FFFF);
    run_access("status w1c", 1, LOC, 32'h2, 4'hF, -1, 1, 1, 32'h0, 32'h0);
    run_access("status rd clr", 0, LOC, 32'h0, 4'hF, -1, 1, 1, 32'h0, 32'hFFFF_FFFF);
    repeat (2) @(posedge wb_clk_i);
    #1 check_output("irq user_irq0 clr", 32'(user_irq), 32'd0);

    // Reset in the middle of a forwarded access, with state to wipe.
    run_access("mask wr all", 1, LOC | 32'h4, 32'hF, 4'hF, -1, 1, 1, 32'h0, 32'h0);
    @(negedge wb_clk_i); ch_irq_i[0] = 1'b1;
    @(negedge wb_clk_i); ch_irq_i[0] = 1'b0;
    ch_delay[1] = 1000;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = 32'h3000_0100; wbs_sel_i = 4'hF;
    repeat (3) @(posedge wb_clk_i);
    #1 check_output("pre-reset stb", 32'(ch_stb_o), 32'h2);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check_output("mid-fwd reset stb", 32'(ch_stb_o), 32'd0);
    check_output("mid-fwd reset ack", 32'(wbs_ack_o), 32'd0);
    check_output("mid-fwd reset user_irq", 32'(user_irq), 32'd0);
    wb_rst_i = 1'b0; wbs_cyc_i = 0; wbs_stb_i = 0;
    flag = 0;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o || ch_stb_o != '0) flag = 1;
    end
    check_output("post-reset quiet", 32'(flag), 32'd0);
    run_access("post-reset status", 0, LOC, 32'h0, 4'hF, -1, 1, 1, 32'h0, 32'hFFFF_FFFF);
    run_access("post-reset mask", 0, LOC | 32'h4, 32'h0, 4'hF, -1, 1, 1, 32'h0, 32'hFFFF_FFFF);

    // Back-to-back channel reads.
    ch_delay[1] = 1; ch_rdata[1] = 32'h1111_0001;
    ch_delay[3] = 3; ch_rdata[3] = 32'h3333_0003;
    run_access("b2b ch1", 0, 32'h3000_0120, 32'h0, 4'hF, 1, 1, 3, 32'h1111_0001, 32'hFFFF_FFFF);
    run_access("b2b ch3", 0, 32'h3000_0330, 32'h0, 4'hF, 3, 1, 5, 32'h3333_0003, 32'hFFFF_FFFF);

    // Randomized traffic over all window indices.
    m_to_flag = 0; m_to_ch = 0;
    for (int n = 0; n < 40; n++) begin
      int idx, d;
      logic [31:0] adr, v, wd;
      bit we;
      idx = $urandom_range(0, 7);
      d   = $urandom_range(0, TIMEOUT + 2);
      v   = $urandom;
      wd  = $urandom;
      we  = 1'($urandom_range(0, 1));
      adr = BASE | (32'(idx) << WIN_BITS) | (32'($urandom_range(0, 63)) << 2);
      if (idx < NUM_CH) begin
        ch_delay[idx] = d; ch_rdata[idx] = v;
        run_access($sformatf("rnd%0d ch%0d", n, idx), we, adr, wd, 4'hF, idx, 1,
                   model_lat(d), model_dat(d, v), we ? 32'h0 : 32'hFFFF_FFFF);
        if (d >= TIMEOUT) begin m_to_flag = 1; m_to_ch = idx; end
      end else if (idx == 7) begin
        run_access($sformatf("rnd%0d id", n), 0, LOC | 32'hC, wd, 4'hF, -1, 1, 1,
                   32'h0001_0004, 32'h00FF_FFFF);
      end else begin
        run_access($sformatf("rnd%0d gap", n), we, adr, wd, 4'hF, -1, 0, 0, 32'h0, 32'h0);
      end
    end
    run_access("rnd to_status", 0, LOC | 32'h8, 32'h0, 4'hF, -1, 1, 1,
               (32'(m_to_ch) << 8) | 32'(m_to_flag), 32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
